// File: rtl/instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// instruction_fetch_stage
//
// Instruction fetch stage of a 5-stage pipeline. Holds the program counter,
// drives the asynchronous-read instruction memory address, and loads the IF/ID
// pipeline register (instruction, PC+1, valid flag). Fetch stops when the halt
// encoding is fetched. After that, only reset restarts it.
//
// Ports
//   i_clock           : single clock, all state updates on its rising edge
//   i_soft_reset      : asynchronous, active-low reset
//   i_enable_etapa    : debug run/step gate; low freezes every register
//   i_stall           : hazard-unit hold of PC and IF/ID
//   i_branch_control  : PC redirect request (takes priority over stall)
//   i_branch_dir      : redirect target
//   i_instruction     : instruction memory read data at o_addr_mem
//   o_addr_mem        : instruction memory address (the PC register)
//   o_adder_pc        : PC+1 belonging to the IF/ID instruction
//   o_instruction     : IF/ID instruction
//   o_valid           : IF/ID holds a real instruction (0 = bubble)
//   o_halt            : fetch is halted
//   o_cant_fetched    : number of valid instructions latched into IF/ID
// -----------------------------------------------------------------------------
module instruction_fetch_stage #(
    parameter int unsigned CANT_BITS_ADDR        = 11,
    parameter int unsigned CANT_BITS_INSTRUCTION = 32,
    parameter logic [CANT_BITS_INSTRUCTION-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF,
    parameter int unsigned CANT_BITS_CONTADOR    = 32
) (
    input  logic                             i_clock,
    input  logic                             i_soft_reset,
    input  logic                             i_enable_etapa,
    input  logic                             i_stall,
    input  logic                             i_branch_control,
    input  logic [CANT_BITS_ADDR-1:0]        i_branch_dir,
    input  logic [CANT_BITS_INSTRUCTION-1:0] i_instruction,
    output logic [CANT_BITS_ADDR-1:0]        o_addr_mem,
    output logic [CANT_BITS_ADDR-1:0]        o_adder_pc,
    output logic [CANT_BITS_INSTRUCTION-1:0] o_instruction,
    output logic                             o_valid,
    output logic                             o_halt,
    output logic [CANT_BITS_CONTADOR-1:0]    o_cant_fetched
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [CANT_BITS_ADDR-1:0]        PC_ONE   = {{(CANT_BITS_ADDR-1){1'b0}}, 1'b1};
    localparam logic [CANT_BITS_CONTADOR-1:0]    CNT_ONE  = {{(CANT_BITS_CONTADOR-1){1'b0}}, 1'b1};
    localparam logic [CANT_BITS_ADDR-1:0]        ADDR_ZERO = {CANT_BITS_ADDR{1'b0}};
    localparam logic [CANT_BITS_INSTRUCTION-1:0] INSTR_ZERO = {CANT_BITS_INSTRUCTION{1'b0}};
    localparam logic [CANT_BITS_CONTADOR-1:0]    CNT_ZERO = {CANT_BITS_CONTADOR{1'b0}};

    // Architectural state
    state_t                             state_r;
    logic                               halt_r;
    logic [CANT_BITS_ADDR-1:0]          pc_r;
    logic [CANT_BITS_ADDR-1:0]          adder_pc_r;
    logic [CANT_BITS_INSTRUCTION-1:0]   instr_r;
    logic                               valid_r;
    logic [CANT_BITS_CONTADOR-1:0]      cnt_r;

    // Next-state values
    state_t                             state_nxt_s;
    logic                               halt_nxt_s;
    logic [CANT_BITS_ADDR-1:0]          pc_nxt_s;
    logic [CANT_BITS_ADDR-1:0]          adder_pc_nxt_s;
    logic [CANT_BITS_INSTRUCTION-1:0]   instr_nxt_s;
    logic                               valid_nxt_s;
    logic [CANT_BITS_CONTADOR-1:0]      cnt_nxt_s;

    // PC+1 wraps naturally at the address width
    logic [CANT_BITS_ADDR-1:0]          pc_inc_s;
    logic                               is_halt_s;

    assign pc_inc_s  = pc_r + PC_ONE;
    assign is_halt_s = (i_instruction == HALT_INSTRUCTION);

    // Next-state selection: branch beats stall beats fetch; halted only emits bubbles
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        adder_pc_nxt_s = adder_pc_r;
        instr_nxt_s    = instr_r;
        valid_nxt_s    = valid_r;
        cnt_nxt_s      = cnt_r;

        if (i_enable_etapa) begin
            case (state_r)
                ST_RUN: begin
                    if (i_branch_control) begin
                        // Redirect and flush; a halt fetched on the wrong path is squashed
                        pc_nxt_s    = i_branch_dir;
                        instr_nxt_s = INSTR_ZERO;
                        valid_nxt_s = 1'b0;
                    end else if (i_stall) begin
                        pc_nxt_s    = pc_r;
                        instr_nxt_s = instr_r;
                    end else begin
                        instr_nxt_s    = i_instruction;
                        adder_pc_nxt_s = pc_inc_s;
                        valid_nxt_s    = 1'b1;
                        cnt_nxt_s      = cnt_r + CNT_ONE;
                        if (is_halt_s) begin
                            // PC parks on the halt instruction
                            pc_nxt_s    = pc_r;
                            state_nxt_s = ST_HALTED;
                        end else begin
                            pc_nxt_s    = pc_inc_s;
                            state_nxt_s = ST_RUN;
                        end
                    end
                end
                ST_HALTED: begin
                    instr_nxt_s = INSTR_ZERO;
                    valid_nxt_s = 1'b0;
                end
                default: begin
                    // Corrupted state encoding: stop fetching safely
                    state_nxt_s = ST_HALTED;
                    instr_nxt_s = INSTR_ZERO;
                    valid_nxt_s = 1'b0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            pc_nxt_s    = pc_r;
        end

        halt_nxt_s = (state_nxt_s == ST_HALTED);
    end

    // State and IF/ID registers with asynchronous active-low reset
    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            state_r    <= ST_RUN;
            halt_r     <= 1'b0;
            pc_r       <= ADDR_ZERO;
            adder_pc_r <= ADDR_ZERO;
            instr_r    <= INSTR_ZERO;
            valid_r    <= 1'b0;
            cnt_r      <= CNT_ZERO;
        end else begin
            state_r    <= state_nxt_s;
            halt_r     <= halt_nxt_s;
            pc_r       <= pc_nxt_s;
            adder_pc_r <= adder_pc_nxt_s;
            instr_r    <= instr_nxt_s;
            valid_r    <= valid_nxt_s;
            cnt_r      <= cnt_nxt_s;
        end
    end

    assign o_addr_mem     = pc_r;
    assign o_adder_pc     = adder_pc_r;
    assign o_instruction  = instr_r;
    assign o_valid        = valid_r;
    assign o_halt         = halt_r;
    assign o_cant_fetched = cnt_r;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// Testbench for instruction_fetch_stage. Two instances share one instruction
// memory and one set of control inputs: a default-sized one and a narrow one
// (4-bit PC, 4-bit counter) that exercises address and counter wrap. Both are
// compared every cycle against a behavioural model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en;
    logic        stall;
    logic        br;
    logic [10:0] dir;

    logic [31:0] mem [0:2047];

    logic [10:0] addr_a, adder_a;
    logic [31:0] imem_a, instr_a;
    logic        valid_a, halt_a;
    logic [31:0] cnt_a;

    logic [3:0]  addr_b, adder_b;
    logic [31:0] imem_b, instr_b;
    logic        valid_b, halt_b;
    logic [3:0]  cnt_b;

    assign imem_a = mem[addr_a];
    assign imem_b = mem[{7'd0, addr_b}];

    instruction_fetch_stage dut_a (
        .i_clock(clk), .i_soft_reset(rst_n), .i_enable_etapa(en), .i_stall(stall),
        .i_branch_control(br), .i_branch_dir(dir), .i_instruction(imem_a),
        .o_addr_mem(addr_a), .o_adder_pc(adder_a), .o_instruction(instr_a),
        .o_valid(valid_a), .o_halt(halt_a), .o_cant_fetched(cnt_a)
    );

    instruction_fetch_stage #(.CANT_BITS_ADDR(4), .CANT_BITS_CONTADOR(4)) dut_b (
        .i_clock(clk), .i_soft_reset(rst_n), .i_enable_etapa(en), .i_stall(stall),
        .i_branch_control(br), .i_branch_dir(dir[3:0]), .i_instruction(imem_b),
        .o_addr_mem(addr_b), .o_adder_pc(adder_b), .o_instruction(instr_b),
        .o_valid(valid_b), .o_halt(halt_b), .o_cant_fetched(cnt_b)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned pc;
        int unsigned adder;
        logic [31:0] instr;
        bit          valid;
        longint unsigned cnt;
        bit          halted;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.pc = 0; m.adder = 0; m.instr = 32'd0; m.valid = 1'b0; m.cnt = 0; m.halted = 1'b0;
        return m;
    endfunction

    // One rising edge of the fetch rules, sizes given as bit counts
    function automatic mdl_t mdl_step(mdl_t m, int abits, int cbits);
        mdl_t n = m;
        int unsigned asize = 1 << abits;
        longint unsigned csize = 64'd1 << cbits;
        logic [31:0] fetched = mem[m.pc];
        if (!en) return n;
        if (m.halted) begin
            n.instr = 32'd0;
            n.valid = 1'b0;
        end else if (br) begin
            n.pc    = dir % asize;
            n.instr = 32'd0;
            n.valid = 1'b0;
        end else if (stall) begin
            // everything held
        end else begin
            n.instr = fetched;
            n.adder = (m.pc + 1) % asize;
            n.valid = 1'b1;
            n.cnt   = (m.cnt + 1) % csize;
            if (fetched == HALT) n.halted = 1'b1;
            else                 n.pc = (m.pc + 1) % asize;
        end
        return n;
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".a.addr"},  64'(addr_a),  64'(ma.pc));
        check({tag, ".a.adder"}, 64'(adder_a), 64'(ma.adder));
        check({tag, ".a.instr"}, 64'(instr_a), 64'(ma.instr));
        check({tag, ".a.valid"}, 64'(valid_a), 64'(ma.valid));
        check({tag, ".a.halt"},  64'(halt_a),  64'(ma.halted));
        check({tag, ".a.cnt"},   64'(cnt_a),   ma.cnt);
        check({tag, ".b.addr"},  64'(addr_b),  64'(mb.pc));
        check({tag, ".b.adder"}, 64'(adder_b), 64'(mb.adder));
        check({tag, ".b.instr"}, 64'(instr_b), 64'(mb.instr));
        check({tag, ".b.valid"}, 64'(valid_b), 64'(mb.valid));
        check({tag, ".b.halt"},  64'(halt_b),  64'(mb.halted));
        check({tag, ".b.cnt"},   64'(cnt_b),   mb.cnt);
    endtask

    // Called one time unit after a rising edge; ends one time unit after the next
    task automatic tick(input string tag);
        mdl_t na, nb;
        na = mdl_step(ma, 11, 32);
        nb = mdl_step(mb, 4, 4);
        @(posedge clk);
        ma = na;
        mb = nb;
        #1;
        check_all(tag);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        ma = mdl_reset();
        mb = mdl_reset();
        #1;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        br = 1'b0; stall = 1'b0; en = 1'b1;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 2048; i++) mem[i] = 32'h1000_0000 | 32'(i);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; stall = 1'b0; br = 1'b0; dir = 11'd0;
        ma = mdl_reset(); mb = mdl_reset();
        init_mem();
        @(posedge clk);
        #1;
        do_reset("rst0");

        // Sequential fetch of A, B, C
        for (int i = 0; i < 3; i++) tick("seq");
        check("seq.cnt3", 64'(cnt_a), 64'd3);
        check("seq.instrC", 64'(instr_a), 64'(mem[2]));
        check("seq.adder3", 64'(adder_a), 64'd3);

        // Branch beats stall at PC=5
        tick("seq"); tick("seq");
        br = 1'b1; stall = 1'b1; dir = 11'd20;
        tick("brst");
        check("brst.pc20", 64'(addr_a), 64'd20);
        check("brst.bubble", 64'(valid_a), 64'd0);
        br = 1'b0; stall = 1'b0;
        tick("brst2");
        check("brst2.instr", 64'(instr_a), 64'(mem[20]));
        check("brst2.adder", 64'(adder_a), 64'd21);

        // Stall then enable-low hold at PC=7
        do_reset("rst1");
        for (int i = 0; i < 7; i++) tick("pre7");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick("stall");
        stall = 1'b0; en = 1'b0;
        for (int i = 0; i < 2; i++) tick("dis");
        check("hold.pc7", 64'(addr_a), 64'd7);
        en = 1'b1;
        tick("resume");
        check("resume.instr", 64'(instr_a), 64'(mem[7]));

        // Halt at address 4
        mem[4] = HALT;
        do_reset("rst2");
        for (int i = 0; i < 5; i++) tick("tohalt");
        check("halt.flag", 64'(halt_a), 64'd1);
        check("halt.pc4", 64'(addr_a), 64'd4);
        check("halt.instr", 64'(instr_a), 64'(HALT));
        br = 1'b1; dir = 11'd30; stall = 1'b1;
        tick("halted");
        check("halted.bubble", 64'(valid_a), 64'd0);
        br = 1'b0; stall = 1'b0;
        tick("halted2");
        do_reset("rst_halt");
        tick("restart");
        check("restart.instr", 64'(instr_a), 64'(mem[0]));

        // Branch at halt time squashes the halt
        for (int i = 0; i < 3; i++) tick("tobr");
        br = 1'b1; dir = 11'd9;
        tick("squash");
        check("squash.nohalt", 64'(halt_a), 64'd0);
        br = 1'b0;
        tick("squash2");
        init_mem();

        // Address wrap on the 4-bit instance
        do_reset("rst3");
        br = 1'b1; dir = 11'd14;
        tick("wrapbr");
        br = 1'b0;
        tick("wrap14");
        tick("wrap15");
        check("wrap.pc0", 64'(addr_b), 64'd0);
        check("wrap.adder0", 64'(adder_b), 64'd0);
        for (int i = 0; i < 16; i++) tick("cntwrap");

        // Randomized segments
        for (int s = 0; s < 25; s++) begin
            for (int i = 0; i < 64; i++)
                mem[i] = ($urandom_range(0, 24) == 0) ? HALT : $urandom;
            do_reset("rrst");
            for (int c = 0; c < 60; c++) begin
                en    = ($urandom_range(0, 7) != 0);
                stall = ($urandom_range(0, 4) == 0);
                br    = ($urandom_range(0, 6) == 0);
                dir   = 11'($urandom_range(0, 63));
                tick("rnd");
            end
            en = 1'b1; stall = 1'b0; br = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter CANT_BITS_ADDR, default 11, SHALL set PC / instruction-memory address width.
REQ-002 Parameter CANT_BITS_INSTRUCTION, default 32, SHALL set instruction width.
REQ-003 Parameter HALT_INSTRUCTION, default 32'hFFFFFFFF, SHALL set the encoding that stops fetch.
REQ-004 Parameter CANT_BITS_CONTADOR, default 32, SHALL set the fetch-counter width.
REQ-005 i_clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 i_soft_reset  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 i_enable_etapa  input  1  SHALL gate every state update (debug run/step control).
REQ-008 i_stall  input  1  SHALL request a hold of PC and IF/ID (hazard unit, load-use).
REQ-009 i_branch_control  input  1  SHALL request a PC redirect (from the branch address calculator).
REQ-010 i_branch_dir  input  CANT_BITS_ADDR  SHALL be the redirect target.
REQ-011 i_instruction  input  CANT_BITS_INSTRUCTION  SHALL be asynchronous-read instruction memory data at o_addr_mem.
REQ-012 o_addr_mem  output  CANT_BITS_ADDR  SHALL equal the PC register (combinational from it).
REQ-013 o_adder_pc  output  CANT_BITS_ADDR  SHALL be the registered PC+1 of the IF/ID instruction.
REQ-014 o_instruction  output  CANT_BITS_INSTRUCTION  SHALL be the registered IF/ID instruction.
REQ-015 o_valid  output  1  SHALL flag o_instruction as a real instruction (0 = bubble/NOP).
REQ-016 o_halt  output  1  SHALL be high while the FSM is in HALTED.
REQ-017 o_cant_fetched  output  CANT_BITS_CONTADOR  SHALL count valid instructions latched into IF/ID.

Function
REQ-018 FSM SHALL have two states, RUN and HALTED; o_halt = (state == HALTED), registered.
REQ-019 Advance condition adv SHALL be i_enable_etapa high and state RUN; i_enable_etapa low SHALL hold every register, including counter.
REQ-020 On adv, priority SHALL be branch > stall > normal fetch.
REQ-021 Branch (adv, i_branch_control=1): PC <= i_branch_dir; IF/ID flushed: o_instruction <= 0, o_valid <= 0, o_adder_pc held; counter unchanged; state stays RUN, even when i_stall=1 or i_instruction = HALT_INSTRUCTION (wrong-path halt squashed).
REQ-022 Stall (adv, no branch, i_stall=1): PC, IF/ID, counter, state held.
REQ-023 Normal fetch: o_instruction <= i_instruction, o_adder_pc <= PC+1, o_valid <= 1, counter +1; PC <= PC+1.
REQ-024 PC+1 SHALL wrap modulo 2^CANT_BITS_ADDR (max address -> 0); counter SHALL wrap modulo 2^CANT_BITS_CONTADOR.
REQ-025 Normal fetch with i_instruction = HALT_INSTRUCTION: IF/ID latches it with o_valid=1, counter +1, PC held (not incremented), state -> HALTED.
REQ-026 HALTED with i_enable_etapa=1: IF/ID SHALL load a bubble (o_instruction 0, o_valid 0); PC, o_adder_pc, counter held; i_branch_control and i_stall ignored.
REQ-027 HALTED SHALL be left only through reset.
REQ-028 Fetch latency: an instruction at PC appears on o_instruction one clock edge after adv with o_addr_mem = PC.

Reset
REQ-029 i_soft_reset low SHALL immediately force PC 0, o_instruction 0, o_adder_pc 0, o_valid 0, o_cant_fetched 0, state RUN, o_halt 0, regardless of clock or i_enable_etapa.
REQ-030 Reset asserted mid-operation (any state, including HALTED or during stall) SHALL discard all in-flight state; first fetch after release is from address 0.

Verification
REQ-031 Sequential fetch: release reset, enable=1, mem[0..2]=A,B,C -> o_instruction A,B,C on edges 1..3, o_adder_pc 1,2,3, o_valid 1, o_cant_fetched 3.
REQ-032 Branch vs stall: at PC=5 assert i_branch_control=1, i_branch_dir=20, i_stall=1 -> next edge PC=20, o_valid 0, o_instruction 0; following edge o_instruction=mem[20], o_adder_pc 21.
REQ-033 Stall/enable hold: i_stall=1 for 3 cycles at PC=7, then enable=0 for 2 cycles -> PC, IF/ID, counter unchanged for all 5 cycles; resume fetches mem[7].
REQ-034 Halt: mem[4]=FFFFFFFF -> o_instruction FFFFFFFF with o_valid 1, o_halt 1, PC stays 4; next enabled edge o_valid 0; branch at PC 4 halt-time squashes halt instead (o_halt stays 0).
REQ-035 Wrap: CANT_BITS_ADDR=4, run from 14 -> PC 15 then 0, o_adder_pc 0 for address 15.
REQ-036 Async reset: pull i_soft_reset low between edges while HALTED -> all outputs zero before next edge; after release fetch restarts at 0.
